scarv_ccx_intc: RTL

SCARV_CCX_INTC -- requirements
Module: scarv_ccx_intc

---
 rtl/scarv_ccx_pkg.sv | 46 ++++
 rtl/scarv_ccx_memif.sv | 14 +
 rtl/scarv_ccx_intc_prio.sv | 22 ++
 rtl/scarv_ccx_intc.sv | 131 +++++++++++++
 4 files changed

// File: rtl/scarv_ccx_pkg.sv
// Shared definitions for the core-complex interrupt controller: register
// offsets, identification constant, register-select enum and decode helpers.
package scarv_ccx_pkg;

   localparam logic [31:0] INTC_OFF_PENDING = 32'h0000_0000;
   localparam logic [31:0] INTC_OFF_ENABLE  = 32'h0000_0004;
   localparam logic [31:0] INTC_OFF_EDGE    = 32'h0000_0008;
   localparam logic [31:0] INTC_OFF_CLAIM   = 32'h0000_000C;
   localparam logic [31:0] INTC_OFF_ID      = 32'h0000_0010;

   localparam logic [31:0] INTC_ID_VALUE    = 32'h1C7C_0001;

   typedef enum logic [2:0] {
      INTC_SEL_PENDING,
      INTC_SEL_ENABLE,
      INTC_SEL_EDGE,
      INTC_SEL_CLAIM,
      INTC_SEL_ID,
      INTC_SEL_NONE
   } intc_sel_e;

   // Map a window-relative byte offset onto a register select.
   function automatic intc_sel_e intc_decode(input logic [31:0] off);
      intc_sel_e sel;
      case (off)
         INTC_OFF_PENDING: sel = INTC_SEL_PENDING;
         INTC_OFF_ENABLE:  sel = INTC_SEL_ENABLE;
         INTC_OFF_EDGE:    sel = INTC_SEL_EDGE;
         INTC_OFF_CLAIM:   sel = INTC_SEL_CLAIM;
         INTC_OFF_ID:      sel = INTC_SEL_ID;
         default:          sel = INTC_SEL_NONE;
      endcase
      return sel;
   endfunction

   // Expand the 4-bit byte strobe into a 32-bit bit mask.
   function automatic logic [31:0] lane_mask(input logic [3:0] strb);
      logic [31:0] m;
      m = '0;
      for (int unsigned b = 0; b < 4; b++) begin
         if (strb[b]) m[b*8 +: 8] = 8'hFF;
      end
      return m;
   endfunction

endpackage

// File: rtl/scarv_ccx_memif.sv
// Simple single-cycle-grant memory-mapped access bus of the core complex.
interface scarv_ccx_memif;
   logic        req;
   logic        wen;
   logic [3:0]  strb;
   logic [31:0] wdata;
   logic [31:0] addr;
   logic        gnt;
   logic        error;
   logic [31:0] rdata;

   modport REQ (output req, wen, strb, wdata, addr, input gnt, error, rdata);
   modport RSP (input req, wen, strb, wdata, addr, output gnt, error, rdata);
endinterface

// File: rtl/scarv_ccx_intc_prio.sv
// Combinational priority encoder: lowest set request index wins.
module scarv_ccx_intc_prio #(
   parameter int unsigned NSRC = 16
) (
   input  logic [NSRC-1:0] req,
   output logic            valid,
   output logic [4:0]      idx
);

   // Scan upward and latch the first set bit.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (req[i] && !valid) begin
            valid = 1'b1;
            idx   = 5'(i);
         end
      end
   end

endmodule

// File: rtl/scarv_ccx_intc.sv
// Core-complex external interrupt controller: synchronises raw sources,
// tracks edge/level pending state, and exposes a small MMIO register window.
module scarv_ccx_intc
   import scarv_ccx_pkg::*;
#(
   parameter int unsigned NSRC        = 16,
   parameter logic [31:0] BASE_ADDR   = 32'h0002_0100,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            f_clk,
   input  logic            g_resetn,
   input  logic [NSRC-1:0] src,
   output logic            int_ext,
   output logic [31:0]     int_ext_cause,
   scarv_ccx_memif.RSP     mmio
);

   localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q;
   logic [NSRC-1:0] lvl, lvl_dly_q, rise;
   logic [2:0]      warm_q;
   logic            armed;

   logic [NSRC-1:0] en_q, edge_q, pend_q;
   logic [NSRC-1:0] en_nxt, edge_nxt, pend_nxt, edge_chg, clr, w_bits;
   logic [NSRC-1:0] pend_vis, active, claim_clr;
   logic            act_valid;
   logic [4:0]      act_idx;

   logic [31:0]     off, wmask, rdata_nxt;
   intc_sel_e       sel;
   logic            acc_err, wr, rd;
   logic            unused_hi;

   assign mmio.gnt  = 1'b1;
   assign unused_hi = ^{wmask[31:NSRC], mmio.wdata[31:NSRC]};

   assign lvl   = sync_q[SYNC_STAGES-1];
   // Edge detection stays masked until the delayed copy holds a post-reset
   // sample, so a source already high at reset release never looks like a rise.
   assign armed = (warm_q == WARM_DONE);
   assign rise  = armed ? (lvl & ~lvl_dly_q) : '0;

   assign pend_vis = (edge_q & pend_q) | (~edge_q & lvl);
   assign active   = pend_vis & en_q;

   scarv_ccx_intc_prio #(.NSRC(NSRC)) u_prio (
      .req   (active),
      .valid (act_valid),
      .idx   (act_idx)
   );

   // Decode the access and compute next register state and read data.
   always_comb begin
      off       = mmio.addr - BASE_ADDR;
      sel       = intc_decode(off);
      wmask     = lane_mask(mmio.strb);
      w_bits    = mmio.wdata[NSRC-1:0] & wmask[NSRC-1:0];
      acc_err   = (mmio.addr[1:0] != 2'b00) || (sel == INTC_SEL_NONE) ||
                  (mmio.wen && (sel == INTC_SEL_CLAIM || sel == INTC_SEL_ID));
      wr        = mmio.req &&  mmio.wen && !acc_err;
      rd        = mmio.req && !mmio.wen && !acc_err;

      claim_clr = '0;
      if (rd && sel == INTC_SEL_CLAIM && act_valid) claim_clr = NSRC'(1) << act_idx;
      clr       = ((wr && sel == INTC_SEL_PENDING) ? w_bits : '0) | claim_clr;

      en_nxt    = (wr && sel == INTC_SEL_ENABLE) ? ((en_q & ~wmask[NSRC-1:0]) | w_bits) : en_q;
      edge_nxt  = (wr && sel == INTC_SEL_EDGE) ? ((edge_q & ~wmask[NSRC-1:0]) | w_bits) : edge_q;
      edge_chg  = edge_nxt ^ edge_q;
      // Set dominates clear; an EDGE mode change drops stored state outright.
      pend_nxt  = ((pend_q & ~clr) | (rise & edge_q)) & ~edge_chg;

      rdata_nxt = '0;
      if (rd) begin
         case (sel)
            INTC_SEL_PENDING: rdata_nxt = 32'(pend_vis);
            INTC_SEL_ENABLE:  rdata_nxt = 32'(en_q);
            INTC_SEL_EDGE:    rdata_nxt = 32'(edge_q);
            INTC_SEL_CLAIM:   rdata_nxt = act_valid ? (32'(act_idx) + 32'd1) : '0;
            INTC_SEL_ID:      rdata_nxt = INTC_ID_VALUE;
            default:          rdata_nxt = '0;
         endcase
      end
   end

   // Source synchronisers, delayed copy for edge detection, warm-up counter.
   always_ff @(posedge f_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         sync_q    <= '0;
         lvl_dly_q <= '0;
         warm_q    <= '0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], src};
         lvl_dly_q <= lvl;
         if (warm_q != WARM_DONE) warm_q <= warm_q + 3'd1;
      end
   end

   // Software-visible register state.
   always_ff @(posedge f_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         en_q   <= '0;
         edge_q <= '0;
         pend_q <= '0;
      end else begin
         en_q   <= en_nxt;
         edge_q <= edge_nxt;
         pend_q <= pend_nxt;
      end
   end

   // Registered interrupt outputs and bus response.
   always_ff @(posedge f_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         int_ext       <= 1'b0;
         int_ext_cause <= '0;
         mmio.rdata    <= '0;
         mmio.error    <= 1'b0;
      end else begin
         int_ext       <= act_valid;
         int_ext_cause <= act_valid ? 32'(act_idx) : '0;
         if (mmio.req) begin
            mmio.rdata <= rdata_nxt;
            mmio.error <= acc_err;
         end
      end
   end

endmodule
